// File: rtl/tick_period_monitor.sv
// Receive-side checker for the divider strobe: measures rising-edge spacing,
// declares lock after consecutive good periods and counts period/timeout errors.
module tick_period_monitor #(
  parameter int unsigned EXP_PERIOD = 40000001,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CW         = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick_in,
  input  logic          clear,
  output logic [CW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          err_pulse,
  output logic [15:0]   err_count,
  output logic          timeout
);

  localparam int unsigned GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  // Window bounds are one bit wider than the counter so EXP_PERIOD+TOL never wraps.
  localparam logic [CW:0] HI = (CW+1)'(EXP_PERIOD) + (CW+1)'(TOL);
  localparam logic [CW:0] LO = (EXP_PERIOD > TOL) ? (CW+1)'(EXP_PERIOD - TOL) : '0;
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_COUNT);

  localparam logic [1:0] S_WAIT_FIRST = 2'd0;
  localparam logic [1:0] S_MEASURE    = 2'd1;
  localparam logic [1:0] S_LOCKED     = 2'd2;

  logic          tick_q, tick_q2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          period_valid_q, period_valid_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;
  logic [15:0]   err_count_q, err_count_d;
  logic          timeout_q, timeout_d;

  logic          tick_edge;
  logic [CW:0]   cnt_ext;
  logic          period_ok;
  logic          overdue;
  logic          err_event;

  assign tick_edge = tick_q & ~tick_q2;
  assign cnt_ext   = {1'b0, cnt_q};
  assign period_ok = (cnt_ext >= LO) && (cnt_ext <= HI);
  assign overdue   = cnt_ext > HI;

  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    err_pulse_d    = 1'b0;
    err_count_d    = err_count_q;
    timeout_d      = timeout_q;
    err_event      = 1'b0;

    if (tick_edge)
      cnt_d = CW'(1);
    else if (&cnt_q)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;

    if (clear) begin
      state_d     = S_WAIT_FIRST;
      good_cnt_d  = '0;
      err_count_d = '0;
      locked_d    = 1'b0;
      timeout_d   = 1'b0;
    end else if (tick_edge) begin
      case (state_q)
        S_WAIT_FIRST: state_d = S_MEASURE;
        S_MEASURE: begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          // First edge after a timeout only reports the stretched gap.
          if (timeout_q) begin
            timeout_d = 1'b0;
          end else if (period_ok) begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_q + 1'b1 == LOCK_N) begin
              state_d  = S_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_cnt_d = '0;
            err_event  = 1'b1;
          end
        end
        S_LOCKED: begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (!period_ok) begin
            locked_d   = 1'b0;
            good_cnt_d = '0;
            err_event  = 1'b1;
            state_d    = S_MEASURE;
          end
        end
        default: state_d = S_WAIT_FIRST;
      endcase
    end else if ((state_q != S_WAIT_FIRST) && !timeout_q && overdue) begin
      timeout_d  = 1'b1;
      locked_d   = 1'b0;
      good_cnt_d = '0;
      err_event  = 1'b1;
      state_d    = S_MEASURE;
    end

    if (err_event) begin
      err_pulse_d = 1'b1;
      if (err_count_q != 16'hFFFF)
        err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q         <= 1'b0;
      tick_q2        <= 1'b0;
      cnt_q          <= '0;
      state_q        <= S_WAIT_FIRST;
      good_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_count_q    <= '0;
      timeout_q      <= 1'b0;
    end else begin
      tick_q         <= tick_in;
      tick_q2        <= tick_q;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_pulse_q    <= err_pulse_d;
      err_count_q    <= err_count_d;
      timeout_q      <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Randomized bench for tick_period_monitor against a spacing-based reference model.
module tb_tick_period_monitor;
  localparam int EXP = 10;
  localparam int TOL = 1;
  localparam int LC  = 3;
  localparam int CW  = 32;
  localparam int HI  = EXP + TOL;
  localparam int LO  = (EXP > TOL) ? EXP - TOL : 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_in = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          err_pulse;
  logic [15:0]   err_count;
  logic          timeout;

  tick_period_monitor #(
    .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_COUNT(LC), .CW(CW)
  ) dut (
    .clock(clk), .reset(rst_n), .tick_in(tick_in), .clear(clear),
    .period(period), .period_valid(period_valid), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: tracks rising-edge sample times and derives outcomes from spacing
  int cyc = 0;
  int last_rise;
  bit s1, s2;
  bit armed, locked_m, timed_m, pv_m, ep_m;
  int streak, errs;
  logic [31:0] period_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    armed = 0; locked_m = 0; timed_m = 0; pv_m = 0; ep_m = 0;
    streak = 0; errs = 0; period_m = 0;
    last_rise = -1000; s1 = 0; s2 = 0;
  endtask

  task automatic check_outputs();
    check_val("period", period, period_m);
    check_val("period_valid", {31'd0, period_valid}, {31'd0, pv_m});
    check_val("locked", {31'd0, locked}, {31'd0, locked_m});
    check_val("err_pulse", {31'd0, err_pulse}, {31'd0, ep_m});
    check_val("err_count", {16'd0, err_count}, errs);
    check_val("timeout", {31'd0, timeout}, {31'd0, timed_m});
  endtask

  task automatic cycle();
    bit smp, clr, rise;
    int gap;
    @(posedge clk);
    smp = tick_in;
    clr = clear;
    #1;
    cyc++;
    rise = s1 && !s2;
    gap  = (cyc - 1) - last_rise;
    pv_m = 0;
    ep_m = 0;
    if (clr) begin
      armed = 0; streak = 0; errs = 0; locked_m = 0; timed_m = 0;
    end else if (rise) begin
      if (armed) begin
        period_m = gap;
        pv_m = 1;
        if (timed_m) timed_m = 0;
        else if (gap >= LO && gap <= HI) begin
          if (!locked_m) begin
            streak++;
            if (streak >= LC) locked_m = 1;
          end
        end else begin
          ep_m = 1; streak = 0; locked_m = 0;
        end
      end
      armed = 1;
    end else if (armed && !timed_m && gap > HI) begin
      timed_m = 1; ep_m = 1; streak = 0; locked_m = 0;
    end
    if (ep_m && errs < 65535) errs++;
    if (rise) last_rise = cyc - 1;
    s2 = s1;
    s1 = smp;
    check_outputs();
  endtask

  task automatic gap_run(input int sp, input int w);
    for (int i = 0; i < sp; i++) begin
      tick_in = (i < w);
      cycle();
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_locked", {31'd0, locked}, 32'd0);
    check_val("rst_err_count", {16'd0, err_count}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sp, w;
    model_reset();
    #1;
    check_outputs();
    #11 rst_n = 1'b1;

    // 1: clean 10-cycle ticks
    tick_in = 0; cycle(); cycle();
    repeat (6) gap_run(10, 1);
    check_val("s1_locked", {31'd0, locked}, 32'd1);
    check_val("s1_err_count", {16'd0, err_count}, 32'd0);
    check_val("s1_period", period, 32'd10);

    // 2: one long gap, then relock
    gap_run(12, 1);
    repeat (5) gap_run(10, 1);
    check_val("s2_err_count", {16'd0, err_count}, 32'd1);
    check_val("s2_locked", {31'd0, locked}, 32'd1);

    // 3: boundary spacings
    gap_run(9, 1); gap_run(11, 1); gap_run(8, 1); gap_run(12, 1);
    repeat (5) gap_run(10, 1);
    check_val("s3_err_count", {16'd0, err_count}, 32'd3);

    // 4: dropped tick
    gap_run(20, 1);
    repeat (5) gap_run(10, 1);
    check_val("s4_err_count", {16'd0, err_count}, 32'd4);
    check_val("s4_timeout", {31'd0, timeout}, 32'd0);

    // 5: wide ticks from a fresh reset
    async_reset();
    tick_in = 0; cycle();
    repeat (6) gap_run(10, 5);
    check_val("s5_locked", {31'd0, locked}, 32'd1);
    check_val("s5_err_count", {16'd0, err_count}, 32'd0);

    // 6: clear while locked with three errors, then reset mid-gap
    gap_run(8, 1); gap_run(12, 1); gap_run(7, 1);
    repeat (5) gap_run(10, 1);
    check_val("s6_err_count", {16'd0, err_count}, 32'd3);
    check_val("s6_locked", {31'd0, locked}, 32'd1);
    clear = 1'b1; tick_in = 1'b0; cycle();
    clear = 1'b0;
    check_val("s6_clr_locked", {31'd0, locked}, 32'd0);
    check_val("s6_clr_err_count", {16'd0, err_count}, 32'd0);
    repeat (4) gap_run(10, 1);
    tick_in = 0; cycle(); cycle(); cycle();
    async_reset();

    // randomized spacings, widths, clears and resets
    for (int n = 0; n < 400; n++) begin
      sp = $urandom_range(2, 24);
      if ($urandom_range(0, 2) != 0) sp = $urandom_range(EXP - TOL - 1, EXP + TOL + 1);
      w = $urandom_range(1, (sp - 1 < 6) ? sp - 1 : 6);
      gap_run(sp, w);
      if ($urandom_range(0, 29) == 0) begin
        clear = 1'b1; tick_in = 1'b0; cycle(); clear = 1'b0;
      end
      if ($urandom_range(0, 79) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
